// File: rtl/urisc_pkg.sv
// Shared definitions for the URISC SUBLEQ core: sequencer states, the halt
// address and the per-instruction step count.
package urisc_pkg;

    typedef enum logic [2:0] {
        FETCH_A,
        FETCH_B,
        FETCH_C,
        LOAD_A,
        LOAD_B,
        EXEC,
        BRANCH,
        HALT
    } seq_state_t;

    localparam int unsigned SEQ_STEPS = 7;

    // All-ones address of the given width; a taken branch here halts the core.
    function automatic logic [63:0] HALT_ADDR(input int unsigned aw);
        if (aw >= 64) begin
            HALT_ADDR = '1;
        end else begin
            HALT_ADDR = (64'd1 << aw) - 64'd1;
        end
    endfunction

endpackage

// File: rtl/phase_onehot_check.sv
// One-hot checker for the divider phase vector with a sticky error flag.
// Only instantiated when URISC_PHASE_CHECK_EN is defined.
module phase_onehot_check #(
    parameter int unsigned PHASES = 4
) (
    input  logic              clkIn,
    input  logic              rstN,
    input  logic [PHASES-1:0] phaseIn,
    output logic              phaseOk,
    output logic              phaseErr
);

    logic w_onehot;
    logic r_err;

    assign w_onehot = $onehot(phaseIn);

    always_ff @(posedge clkIn) begin
        if (!rstN) begin
            r_err <= 1'b0;
        end else if (!w_onehot) begin
            r_err <= 1'b1;
        end
    end

    // The offending vector itself must not step the sequencer either.
    assign phaseOk  = w_onehot & ~r_err;
    assign phaseErr = r_err;

endmodule

// File: rtl/subleq_sequencer.sv
// SUBLEQ instruction sequencer: walks one instruction through seven phase-gated
// steps against a single-port synchronous memory. Optional URISC_PHASE_CHECK_EN.
module subleq_sequencer
    import urisc_pkg::*;
#(
    parameter int unsigned PHASES     = 4,
    parameter int unsigned STEP_PHASE = 0,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic              clkIn,
    input  logic              rstN,
    input  logic [PHASES-1:0] phaseIn,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memRe,
    input  logic [DATA_W-1:0] memRdData,
    output logic              memWe,
    output logic [DATA_W-1:0] memWrData,
    output logic [ADDR_W-1:0] pcOut,
    output logic              instrDone,
    output logic              halted
`ifdef URISC_PHASE_CHECK_EN
    ,
    output logic              phaseErr
`endif
);

    localparam logic [ADDR_W-1:0] L_HALT_PC  = ADDR_W'(HALT_ADDR(ADDR_W));
    localparam logic [ADDR_W-1:0] L_RESET_PC = ADDR_W'(RESET_PC);

    seq_state_t        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_a;
    logic [ADDR_W-1:0] r_b;
    logic [ADDR_W-1:0] r_c;
    logic [DATA_W-1:0] r_ma;
    logic              r_le;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_re;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wr_data;
    logic              r_done;
    logic              r_halted;

    logic              w_step;
    logic [DATA_W-1:0] w_res;
    logic              w_le;

`ifdef URISC_PHASE_CHECK_EN
    logic w_phase_ok;

    phase_onehot_check #(
        .PHASES(PHASES)
    ) u_phase_check (
        .clkIn   (clkIn),
        .rstN    (rstN),
        .phaseIn (phaseIn),
        .phaseOk (w_phase_ok),
        .phaseErr(phaseErr)
    );

    assign w_step = phaseIn[STEP_PHASE] & ~r_halted & w_phase_ok;
`else
    logic w_unused_phase;

    assign w_unused_phase = ^phaseIn;
    assign w_step         = phaseIn[STEP_PHASE] & ~r_halted;
`endif

    // memRdData holds mb during EXEC: the read at b was issued on the LOAD_B step.
    assign w_res = memRdData - r_ma;
    assign w_le  = w_res[DATA_W-1] | (w_res == '0);

    always_ff @(posedge clkIn) begin
        if (!rstN) begin
            r_state       <= FETCH_A;
            r_pc          <= L_RESET_PC;
            r_a           <= '0;
            r_b           <= '0;
            r_c           <= '0;
            r_ma          <= '0;
            r_le          <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_re      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_wr_data <= '0;
            r_done        <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_mem_re <= 1'b0;
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;
            if (w_step) begin
                case (r_state)
                    FETCH_A: begin
                        r_mem_addr <= r_pc;
                        r_mem_re   <= 1'b1;
                        r_state    <= FETCH_B;
                    end
                    FETCH_B: begin
                        r_a        <= memRdData[ADDR_W-1:0];
                        r_mem_addr <= r_pc + ADDR_W'(1);
                        r_mem_re   <= 1'b1;
                        r_state    <= FETCH_C;
                    end
                    FETCH_C: begin
                        r_b        <= memRdData[ADDR_W-1:0];
                        r_mem_addr <= r_pc + ADDR_W'(2);
                        r_mem_re   <= 1'b1;
                        r_state    <= LOAD_A;
                    end
                    LOAD_A: begin
                        r_c        <= memRdData[ADDR_W-1:0];
                        r_mem_addr <= r_a;
                        r_mem_re   <= 1'b1;
                        r_state    <= LOAD_B;
                    end
                    LOAD_B: begin
                        r_ma       <= memRdData;
                        r_mem_addr <= r_b;
                        r_mem_re   <= 1'b1;
                        r_state    <= EXEC;
                    end
                    EXEC: begin
                        r_mem_addr    <= r_b;
                        r_mem_wr_data <= w_res;
                        r_mem_we      <= 1'b1;
                        r_le          <= w_le;
                        r_state       <= BRANCH;
                    end
                    BRANCH: begin
                        r_done <= 1'b1;
                        if (r_le && (r_c == L_HALT_PC)) begin
                            r_halted <= 1'b1;
                            r_state  <= HALT;
                        end else if (r_le) begin
                            r_pc    <= r_c;
                            r_state <= FETCH_A;
                        end else begin
                            r_pc    <= r_pc + ADDR_W'(3);
                            r_state <= FETCH_A;
                        end
                    end
                    HALT: begin
                        r_state <= HALT;
                    end
                    default: begin
                        r_state <= FETCH_A;
                    end
                endcase
            end
        end
    end

    assign memAddr   = r_mem_addr;
    assign memRe     = r_mem_re;
    assign memWe     = r_mem_we;
    assign memWrData = r_mem_wr_data;
    assign pcOut     = r_pc;
    assign instrDone = r_done;
    assign halted    = r_halted;

endmodule

// File: tb/tb_subleq_sequencer.sv
// Directed bench for subleq_sequencer: two instances (RESET_PC 0 and 0xFFFE)
// with a free-running 4-phase divider model and synchronous memory models.
module tb_subleq_sequencer;

    logic        clkIn;
    logic        rstN;
    logic [3:0]  phaseIn;

    logic [15:0] memAddr0, memAddr1;
    logic        memRe0, memRe1;
    logic        memWe0, memWe1;
    logic [15:0] memWrData0, memWrData1;
    logic [15:0] rd0, rd1;
    logic [15:0] pcOut0, pcOut1;
    logic        instrDone0, instrDone1;
    logic        halted0, halted1;
`ifdef URISC_PHASE_CHECK_EN
    logic        phaseErr0, phaseErr1;
`endif

    subleq_sequencer #(
        .PHASES(4), .STEP_PHASE(0), .DATA_W(16), .ADDR_W(16), .RESET_PC(0)
    ) u_dut (
        .clkIn    (clkIn),
        .rstN     (rstN),
        .phaseIn  (phaseIn),
        .memAddr  (memAddr0),
        .memRe    (memRe0),
        .memRdData(rd0),
        .memWe    (memWe0),
        .memWrData(memWrData0),
        .pcOut    (pcOut0),
        .instrDone(instrDone0),
`ifdef URISC_PHASE_CHECK_EN
        .phaseErr (phaseErr0),
`endif
        .halted   (halted0)
    );

    subleq_sequencer #(
        .PHASES(4), .STEP_PHASE(0), .DATA_W(16), .ADDR_W(16), .RESET_PC(16'hFFFE)
    ) u_dut_wrap (
        .clkIn    (clkIn),
        .rstN     (rstN),
        .phaseIn  (phaseIn),
        .memAddr  (memAddr1),
        .memRe    (memRe1),
        .memRdData(rd1),
        .memWe    (memWe1),
        .memWrData(memWrData1),
        .pcOut    (pcOut1),
        .instrDone(instrDone1),
`ifdef URISC_PHASE_CHECK_EN
        .phaseErr (phaseErr1),
`endif
        .halted   (halted1)
    );

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    logic [15:0] mem0 [0:65535];
    logic [15:0] mem1 [0:65535];

    int          n_checks = 0;
    int          n_err    = 0;
    int          n_edge   = 0;
    int          phase_cnt = 0;
    logic        phase_glitch = 1'b0;

    logic        p_re0 = 1'b0, p_we0 = 1'b0, p_re1 = 1'b0, p_we1 = 1'b0;
    logic [15:0] p_addr0 = '0, p_wd0 = '0, p_addr1 = '0, p_wd1 = '0;

    logic [15:0] re_q0[$];
    logic [15:0] re_q1[$];
    int          first_re0  = -1;
    int          first_done0 = -1;
    int          done_cnt0  = 0;
    int          we_total0  = 0;
    int          saved;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clkIn cycle: drive phase, then act as memory and monitor #1 after the edge.
    task automatic tick();
        phaseIn = phase_glitch ? 4'b0011 : (4'b0001 << phase_cnt);
        @(posedge clkIn);
        #1;
        n_edge++;
        phase_cnt = (phase_cnt + 1) % 4;
        if (p_re0) rd0 = mem0[p_addr0];
        if (p_we0) mem0[p_addr0] = p_wd0;
        if (p_re1) rd1 = mem1[p_addr1];
        if (p_we1) mem1[p_addr1] = p_wd1;
        p_re0 = memRe0; p_we0 = memWe0; p_addr0 = memAddr0; p_wd0 = memWrData0;
        p_re1 = memRe1; p_we1 = memWe1; p_addr1 = memAddr1; p_wd1 = memWrData1;
        if (memRe0) begin
            re_q0.push_back(memAddr0);
            if (first_re0 < 0) first_re0 = n_edge;
        end
        if (memRe1) re_q1.push_back(memAddr1);
        if (memWe0) we_total0++;
        if (instrDone0) begin
            done_cnt0++;
            if (done_cnt0 == 1) first_done0 = n_edge;
        end
    endtask

    // Hold reset for three edges; the first step edge after release is edge 4.
    task automatic do_reset();
        rstN = 1'b0;
        repeat (3) tick();
        rstN      = 1'b1;
        n_edge    = 0;
        phase_cnt = 1;
        first_re0 = -1;
        first_done0 = -1;
        done_cnt0 = 0;
        re_q0.delete();
        re_q1.delete();
    endtask

    task automatic run_done(input string tag, input int budget);
        int k = 0;
        while (done_cnt0 == 0 && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(done_cnt0 != 0), 32'd1);
    endtask

    initial begin
        rstN    = 1'b0;
        phaseIn = 4'b0001;
        rd0     = '0;
        rd1     = '0;

        // Non-taken branch on instance 0, PC wrap on instance 1.
        mem0[0] = 16'd10; mem0[1] = 16'd11; mem0[2] = 16'd0;
        mem0[10] = 16'd3; mem0[11] = 16'd5;
        mem1[16'hFFFE] = 16'd20; mem1[16'hFFFF] = 16'd21; mem1[0] = 16'd0;
        mem1[20] = 16'd5; mem1[21] = 16'd9;
        do_reset();
        check("rst_pc0", 32'(pcOut0), 32'h0);
        check("rst_pc1", 32'(pcOut1), 32'hFFFE);
        check("rst_re", 32'(memRe0), 32'd0);
        check("rst_we", 32'(memWe0), 32'd0);
        check("rst_done", 32'(instrDone0), 32'd0);
        check("rst_halt", 32'(halted0), 32'd0);
        check("rst_addr", 32'(memAddr0), 32'h0);
        check("rst_wdata", 32'(memWrData0), 32'h0);
`ifdef URISC_PHASE_CHECK_EN
        check("rst_perr", 32'(phaseErr0), 32'd0);
`endif
        run_done("nt_timeout", 60);
        check("nt_done_cycle", 32'(first_done0), 32'd28);
        check("nt_first_re", 32'(first_re0), 32'd4);
        check("nt_pc", 32'(pcOut0), 32'd3);
        check("nt_mem11", 32'(mem0[11]), 32'd2);
        check("nt_nreads", 32'(re_q0.size()), 32'd5);
        if (re_q0.size() >= 5) begin
            check("nt_rd0", 32'(re_q0[0]), 32'd0);
            check("nt_rd1", 32'(re_q0[1]), 32'd1);
            check("nt_rd2", 32'(re_q0[2]), 32'd2);
            check("nt_rd3", 32'(re_q0[3]), 32'd10);
            check("nt_rd4", 32'(re_q0[4]), 32'd11);
        end
        tick();
        check("nt_done_1cyc", 32'(instrDone0), 32'd0);
        check("wr_pc", 32'(pcOut1), 32'h0001);
        check("wr_mem21", 32'(mem1[21]), 32'd4);
        check("wr_nreads", 32'(re_q1.size()), 32'd5);
        if (re_q1.size() >= 5) begin
            check("wr_rd0", 32'(re_q1[0]), 32'hFFFE);
            check("wr_rd1", 32'(re_q1[1]), 32'hFFFF);
            check("wr_rd2", 32'(re_q1[2]), 32'h0000);
            check("wr_rd3", 32'(re_q1[3]), 32'd20);
        end

        // Taken on zero.
        mem0[0] = 16'd10; mem0[1] = 16'd11; mem0[2] = 16'd40;
        mem0[10] = 16'd5; mem0[11] = 16'd5;
        do_reset();
        run_done("tz_timeout", 60);
        check("tz_pc", 32'(pcOut0), 32'd40);
        check("tz_mem11", 32'(mem0[11]), 32'd0);

        // Taken on negative: 5 - 7 = -2.
        mem0[10] = 16'd7; mem0[11] = 16'd5;
        do_reset();
        run_done("tn_timeout", 60);
        check("tn_pc", 32'(pcOut0), 32'd40);
        check("tn_mem11", 32'(mem0[11]), 32'hFFFE);

        // Halt: A == B clears mem[10], target all ones.
        mem0[0] = 16'd10; mem0[1] = 16'd10; mem0[2] = 16'hFFFF;
        mem0[10] = 16'd123;
        do_reset();
        run_done("ht_timeout", 60);
        check("ht_halted", 32'(halted0), 32'd1);
        check("ht_pc", 32'(pcOut0), 32'd0);
        check("ht_mem10", 32'(mem0[10]), 32'd0);
        saved = re_q0.size();
        repeat (100) tick();
        check("ht_no_reads", 32'(re_q0.size()), 32'(saved));
        check("ht_sticky", 32'(halted0), 32'd1);
        check("ht_one_done", 32'(done_cnt0), 32'd1);

        // Reset landing on the EXEC step edge (edge 24) drops the write.
        mem0[0] = 16'd10; mem0[1] = 16'd11; mem0[2] = 16'd0;
        mem0[10] = 16'd1; mem0[11] = 16'd77;
        do_reset();
        repeat (23) tick();
        saved = we_total0;
        do_reset();
        check("rx_no_write", 32'(we_total0), 32'(saved));
        check("rx_mem11", 32'(mem0[11]), 32'd77);
        check("rx_pc", 32'(pcOut0), 32'd0);
        for (int k = 0; k < 10 && first_re0 < 0; k++) tick();
        check("rx_first_re", 32'(first_re0), 32'd4);
        if (re_q0.size() >= 1) check("rx_first_addr", 32'(re_q0[0]), 32'd0);

`ifdef URISC_PHASE_CHECK_EN
        // Two-hot phase on what would be a step edge freezes everything.
        do_reset();
        repeat (3) tick();
        phase_glitch = 1'b1;
        tick();
        phase_glitch = 1'b0;
        check("pe_flag", 32'(phaseErr0), 32'd1);
        check("pe_no_re_now", 32'(memRe0), 32'd0);
        saved = we_total0;
        repeat (60) tick();
        check("pe_no_reads", 32'(re_q0.size()), 32'd0);
        check("pe_no_writes", 32'(we_total0), 32'(saved));
        check("pe_sticky", 32'(phaseErr0), 32'd1);
        check("pe_pc", 32'(pcOut0), 32'd0);
        do_reset();
        check("pe_cleared", 32'(phaseErr0), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/subleq_sequencer.md
# subleq_sequencer

Instruction sequencer for the URISC SUBLEQ core, sitting directly downstream of the phase-clock divider. It consumes the divider's one-hot phase vector as a step enable and walks one SUBLEQ instruction (`mem[B] = mem[B] - mem[A]; if result <= 0 then PC = C else PC = PC + 3`) through a seven-step state machine. It drives a single-port synchronous memory and reports PC, halt and per-instruction completion.

## Interface
- `PHASES`, 4: width of the phase vector from the divider; must be ≥ 2.
- `STEP_PHASE`, 0: index of the phase bit that enables a step.
- `DATA_W`, 16: memory word width, signed two's complement.
- `ADDR_W`, 16: address and PC width; `ADDR_W` ≤ `DATA_W`.
- `RESET_PC`, 0: PC value loaded on reset.
- `clkIn`  in  1  system clock, the same clock that feeds the divider.
- `rstN`  in  1  reset, synchronous, active-low.
- `phaseIn`  in  PHASES  one-hot phase vector from the divider, sampled on `clkIn`.
- `memAddr`  out  ADDR_W  memory address.
- `memRe`  out  1  read strobe, one `clkIn` cycle.
- `memRdData`  in  DATA_W  read data, valid one cycle after `memRe`.
- `memWe`  out  1  write strobe, one `clkIn` cycle.
- `memWrData`  out  DATA_W  write data.
- `pcOut`  out  ADDR_W  current instruction address.
- `instrDone`  out  1  one-cycle pulse when an instruction retires.
- `halted`  out  1  sticky halt flag.
- `phaseErr`  out  1  sticky illegal-phase flag; present only with `URISC_PHASE_CHECK_EN`.

## Operation
- **Step enable:** `step = phaseIn[STEP_PHASE] & ~halted`. The state machine advances only on `clkIn` edges where `step` is 1. The strobes `memRe` and `memWe` are registered and asserted only in the cycle after a step edge.
- **States, each taken on a step:**
  - FETCH_A: issue read at `pc`.
  - FETCH_B: capture `a`; issue read at `pc+1`.
  - FETCH_C: capture `b`; issue read at `pc+2`.
  - LOAD_A: capture `c`; issue read at `a[ADDR_W-1:0]`.
  - LOAD_B: capture `ma`; issue read at `b[ADDR_W-1:0]`.
  - EXEC: capture `mb`; `res = mb - ma` (DATA_W wrap, no saturation); write `res` to `b`; latch `le = res[DATA_W-1] | (res == 0)`.
  - BRANCH: apply the branch rule below, pulse `instrDone`, go to FETCH_A.
  - HALT: terminal state; exited only by reset.
- **Branch rule:**
  - If `le`: `pc = c[ADDR_W-1:0]`.
  - Otherwise: `pc = pc + 3` mod 2^ADDR_W.
  - If `le` and `c[ADDR_W-1:0]` is all ones, go to HALT and set `halted`. `pc` holds the halting instruction's address.
- **Address arithmetic:** `pc+1` and `pc+2` wrap modulo 2^ADDR_W.
- **Reset:** on an edge with `rstN` = 0:
  - State goes to FETCH_A and `pc` loads `RESET_PC`.
  - `memRe`, `memWe`, `instrDone`, `halted` and `phaseErr` clear, and `memAddr` and `memWrData` go to 0.
  - This applies mid-instruction too; an in-flight write strobe is dropped on the same edge.
- **Aliasing:** if A == B, the result is 0, so the branch is taken (clears the location). No special casing is needed.

## Timing
- A read issued at step edge k is presented on `memAddr`/`memRe` during cycle k+1. Memory samples it at edge k+1, and data is valid after k+1. Data is captured at the next step edge, at least k+2 since `PHASES` ≥ 2.
- Instruction latency is 7 step edges, i.e. `7*PHASES` `clkIn` cycles with a free-running divider.
- `instrDone` is high for exactly one `clkIn` cycle after the BRANCH edge.
- `pcOut` updates on the BRANCH edge.
- `phaseIn` bits other than `STEP_PHASE` are ignored, except by the checker.

## Configuration
- `URISC_PHASE_CHECK_EN` defined:
  - Each `clkIn` edge checks `phaseIn` is one-hot (`$onehot`).
  - On violation, `phaseErr` sets and stays set until reset.
  - While `phaseErr` is set, `step` is forced to 0, freezing the sequencer.
- Not defined: no checker, no `phaseErr` port, and `step` ignores one-hot validity.

## Structure
- Shared package `urisc_pkg` holds:
  - the `seq_state_t` enum: FETCH_A, FETCH_B, FETCH_C, LOAD_A, LOAD_B, EXEC, BRANCH, HALT;
  - the `HALT_ADDR` all-ones function of `ADDR_W`;
  - the step count constant `SEQ_STEPS` = 7.
- One sub-module, `phase_onehot_check`: the one-hot checker with its sticky flag, instantiated only under the macro. The datapath and FSM stay in one module.

## Test plan
- **Non-taken branch:** `PHASES`=4, free-running divider model, mem[0..2]={10,11,0}, mem[10]=3, mem[11]=5 → mem[11]=2, `pc`=3, `instrDone` pulses at cycle 28 after reset release.
- **Taken branch on zero:** mem[0..2]={10,11,40}, mem[10]=5, mem[11]=5 → mem[11]=0, `pc`=40.
- **Halt:** mem[0..2]={10,10,0xFFFF} → mem[10]=0, `halted`=1, `pcOut`=0, no further `memRe` for 100 cycles.
- **PC wrap:** `RESET_PC`=0xFFFE, operands at 0xFFFE, 0xFFFF, 0x0000, not taken → reads hit 0xFFFE, 0xFFFF, 0x0000, then `pc`=0x0001.
- **Reset mid-EXEC:** drop `rstN` in the cycle `memWe` would assert → no write observed, `pc`=`RESET_PC`, next `memRe` address is `RESET_PC`.
- **Illegal phase (`URISC_PHASE_CHECK_EN`):** drive `phaseIn`=4'b0011 for one cycle → `phaseErr`=1, state frozen, no `memRe`/`memWe` until reset.
